// File: rtl/bsg_counter_clear_up_multi.sv
// Bank of independent clear/up counters with wrap or saturate at max_val_p,
// sticky overflow and shared-threshold compare. Optional snapshot: BSG_COUNTER_SNAPSHOT_EN.
module bsg_counter_clear_up_multi #(
  parameter int els_p      = 4,
  parameter int max_val_p  = 9,
  parameter int max_step_p = 1,
  parameter int init_val_p = 0,
  parameter bit saturate_p = 1'b0,
  localparam int ptr_width_lp  = $clog2(max_val_p + 1),
  localparam int step_width_lp = $clog2(max_step_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [els_p-1:0]                  clear_i,
  input  logic [els_p*step_width_lp-1:0]    up_i,
  input  logic [ptr_width_lp-1:0]           thresh_i,
`ifdef BSG_COUNTER_SNAPSHOT_EN
  input  logic                              snapshot_i,
  output logic [els_p*ptr_width_lp-1:0]     snap_count_o,
  output logic                              snap_v_o,
`endif
  output logic [els_p*ptr_width_lp-1:0]     count_o,
  output logic [els_p-1:0]                  overflow_o,
  output logic [els_p-1:0]                  at_thresh_o
);

  localparam logic [ptr_width_lp:0]   lp_max  = (ptr_width_lp + 1)'(max_val_p);
  localparam logic [ptr_width_lp:0]   lp_mod  = (ptr_width_lp + 1)'(max_val_p + 1);
  localparam logic [ptr_width_lp-1:0] lp_init = ptr_width_lp'(init_val_p);

  logic [els_p-1:0][ptr_width_lp-1:0] r_count;
  logic [els_p-1:0]                   r_ovf;

  logic [els_p-1:0][ptr_width_lp:0]   w_base;
  logic [els_p-1:0][ptr_width_lp:0]   w_sum;
  logic [els_p-1:0][ptr_width_lp:0]   w_wrap;
  logic [els_p-1:0]                   w_over;
  logic [els_p-1:0][ptr_width_lp-1:0] w_next_count;
  logic [els_p-1:0]                   w_next_ovf;

  // Sum is one bit wider than the count so the carry past max_val_p is visible.
  always_comb begin
    w_base       = '0;
    w_sum        = '0;
    w_wrap       = '0;
    w_over       = '0;
    w_next_count = '0;
    w_next_ovf   = '0;
    for (int i = 0; i < els_p; i++) begin
      w_base[i] = clear_i[i] ? '0 : {1'b0, r_count[i]};
      w_sum[i]  = w_base[i] + (ptr_width_lp + 1)'(up_i[i*step_width_lp +: step_width_lp]);
      w_wrap[i] = w_sum[i] - lp_mod;
      w_over[i] = (w_sum[i] > lp_max);
      if (!w_over[i])
        w_next_count[i] = w_sum[i][ptr_width_lp-1:0];
      else if (saturate_p)
        w_next_count[i] = lp_max[ptr_width_lp-1:0];
      else
        w_next_count[i] = w_wrap[i][ptr_width_lp-1:0];
      w_next_ovf[i] = (clear_i[i] ? 1'b0 : r_ovf[i]) | w_over[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) r_count[i] <= lp_init;
      r_ovf <= '0;
    end else begin
      r_count <= w_next_count;
      r_ovf   <= w_next_ovf;
    end
  end

  assign count_o    = r_count;
  assign overflow_o = r_ovf;

  always_comb begin
    at_thresh_o = '0;
    for (int i = 0; i < els_p; i++) at_thresh_o[i] = (r_count[i] >= thresh_i);
  end

`ifdef BSG_COUNTER_SNAPSHOT_EN
  logic [els_p*ptr_width_lp-1:0] r_snap_count;
  logic                          r_snap_v;

  // Captures the pre-update counts, so a same-cycle clear/up is not seen.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_snap_count <= '0;
      r_snap_v     <= 1'b0;
    end else if (snapshot_i) begin
      r_snap_count <= r_count;
      r_snap_v     <= 1'b1;
    end
  end

  assign snap_count_o = r_snap_count;
  assign snap_v_o     = r_snap_v;
`endif

`ifndef SYNTHESIS
  if (els_p < 1 || max_val_p < 1 || max_step_p < 1 || max_step_p > max_val_p ||
      init_val_p < 0 || init_val_p > max_val_p) begin : g_bad_params
    $error("bsg_counter_clear_up_multi: invalid parameter combination");
  end

  always @(posedge clk_i) begin
    if (reset_n_i === 1'b1) begin
      for (int i = 0; i < els_p; i++) begin
        if (int'(up_i[i*step_width_lp +: step_width_lp]) > max_step_p)
          $error("bsg_counter_clear_up_multi: up_i[%0d] exceeds max_step_p", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_counter_clear_up_multi.sv
// Directed bench for bsg_counter_clear_up_multi: a wrap instance and a saturate
// instance checked every cycle against an arithmetic model, plus literal pins.
module tb_bsg_counter_clear_up_multi;
  localparam int PW = 4;  // width of 0..9
  localparam int SW = 2;  // width of 0..3

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    clr;
  logic [4*SW-1:0] up;
  logic [PW-1:0] thresh;
  logic [4*PW-1:0] cnt [2];
  logic [3:0]    ovf [2];
  logic [3:0]    at  [2];
`ifdef BSG_COUNTER_SNAPSHOT_EN
  logic          snapshot;
  logic [4*PW-1:0] snap [2];
  logic          snap_v [2];
  int            ms [2][4];
  bit            msv [2];
`endif

  int  mc [2][4];
  bit  mo [2][4];
  bit  m_valid = 1'b0;
  int  n_total = 0;
  int  n_pass  = 0;

  always #5 clk = ~clk;

  bsg_counter_clear_up_multi #(.els_p(4), .max_val_p(9), .max_step_p(3), .init_val_p(3), .saturate_p(1'b0)) dut_wrap (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .up_i(up), .thresh_i(thresh),
`ifdef BSG_COUNTER_SNAPSHOT_EN
    .snapshot_i(snapshot), .snap_count_o(snap[0]), .snap_v_o(snap_v[0]),
`endif
    .count_o(cnt[0]), .overflow_o(ovf[0]), .at_thresh_o(at[0]));

  bsg_counter_clear_up_multi #(.els_p(4), .max_val_p(9), .max_step_p(3), .init_val_p(3), .saturate_p(1'b1)) dut_sat (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .up_i(up), .thresh_i(thresh),
`ifdef BSG_COUNTER_SNAPSHOT_EN
    .snapshot_i(snapshot), .snap_count_o(snap[1]), .snap_v_o(snap_v[1]),
`endif
    .count_o(cnt[1]), .overflow_o(ovf[1]), .at_thresh_o(at[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
  endtask

  // Model: wrap instance counts modulo 10, saturate instance clamps at 9.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin mc[k][i] = 3; mo[k][i] = 1'b0; end
`ifdef BSG_COUNTER_SNAPSHOT_EN
        for (int i = 0; i < 4; i++) ms[k][i] = 0;
        msv[k] = 1'b0;
`endif
      end
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
`ifdef BSG_COUNTER_SNAPSHOT_EN
        if (snapshot) begin
          for (int i = 0; i < 4; i++) ms[k][i] = mc[k][i];
          msv[k] = 1'b1;
        end
`endif
        for (int i = 0; i < 4; i++) begin
          int s;
          s = (clr[i] ? 0 : mc[k][i]) + int'(up[i*SW +: SW]);
          if (clr[i]) mo[k][i] = 1'b0;
          if (s > 9) begin
            mo[k][i] = 1'b1;
            mc[k][i] = (k == 0) ? (s % 10) : 9;
          end else begin
            mc[k][i] = s;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [4*PW-1:0] ec;
        logic [3:0] eo, ea;
        for (int i = 0; i < 4; i++) begin
          ec[i*PW +: PW] = PW'(mc[k][i]);
          eo[i] = mo[k][i];
          ea[i] = (mc[k][i] >= int'(thresh));
        end
        chk($sformatf("count_o[inst%0d]", k), int'(cnt[k]), int'(ec));
        chk($sformatf("overflow_o[inst%0d]", k), int'(ovf[k]), int'(eo));
        chk($sformatf("at_thresh_o[inst%0d]", k), int'(at[k]), int'(ea));
`ifdef BSG_COUNTER_SNAPSHOT_EN
        for (int i = 0; i < 4; i++) ec[i*PW +: PW] = PW'(ms[k][i]);
        chk($sformatf("snap_count_o[inst%0d]", k), int'(snap[k]), int'(ec));
        chk($sformatf("snap_v_o[inst%0d]", k), int'(snap_v[k]), int'(msv[k]));
`endif
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] c, input int u0, input int u1, input int u2, input int u3);
    rst_n = r;
    clr   = c;
    up    = {SW'(u3), SW'(u2), SW'(u1), SW'(u0)};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = '0; up = '1; thresh = 4'd2;
`ifdef BSG_COUNTER_SNAPSHOT_EN
    snapshot = 1'b0;
`endif
    cyc(0, 4'h0, 3, 3, 3, 3);
    cyc(0, 4'h0, 3, 3, 3, 3);
    chk("reset_count_wrap", int'(cnt[0]), 'h3333);
    chk("reset_count_sat", int'(cnt[1]), 'h3333);
    chk("reset_ovf", int'(ovf[0]), 0);
    chk("reset_at_thresh", int'(at[0]), 'hF);

    cyc(1, 4'hF, 0, 0, 0, 0);
    chk("clear_all", int'(cnt[0]), 0);
    cyc(1, 4'h0, 3, 1, 3, 2);
    cyc(1, 4'h0, 3, 1, 3, 0);
    cyc(1, 4'h0, 2, 1, 2, 0);
    chk("ch0_at_8", int'(cnt[0][3:0]), 8);
    cyc(1, 4'h0, 3, 0, 3, 0);
    chk("wrap_ch0", int'(cnt[0][3:0]), 1);
    chk("wrap_model_ch0", mc[0][0], 1);
    chk("wrap_ovf0", int'(ovf[0][0]), 1);
    chk("sat_ch0", int'(cnt[1][3:0]), 9);
    chk("sat_ovf0", int'(ovf[1][0]), 1);
    cyc(1, 4'h0, 1, 0, 3, 0);
    cyc(1, 4'h0, 2, 0, 3, 0);
    chk("wrap_ch0_after", int'(cnt[0][3:0]), 4);
    chk("wrap_ovf0_sticky", int'(ovf[0][0]), 1);
    chk("sat_ch0_hold", int'(cnt[1][3:0]), 9);
    chk("ch2_at_7", int'(cnt[0][11:8]), 7);
    chk("ch2_ovf_set", int'(ovf[0][2]), 1);

    cyc(1, 4'h4, 0, 0, 2, 0);
    chk("clr_up_ch2", int'(cnt[0][11:8]), 2);
    chk("clr_up_ovf2", int'(ovf[0][2]), 0);
    chk("clr_up_sat_ch2", int'(cnt[1][11:8]), 2);
    chk("clr_up_others", int'({cnt[0][15:12], cnt[0][7:0]}), 'h234);
    chk("clr_up_ovf0_kept", int'(ovf[0][0]), 1);

    thresh = 4'd5;
    cyc(1, 4'h0, 0, 1, 0, 0);
    chk("thr_cnt4", int'(at[0][1]), 0);
    cyc(1, 4'h0, 0, 1, 0, 0);
    chk("thr_cnt5", int'(at[0][1]), 1);
    cyc(1, 4'h0, 0, 1, 0, 0);
    chk("thr_cnt6", int'(at[0][1]), 1);
    chk("thr_model_cnt6", mc[0][1], 6);
    thresh = 4'd7;
    #1;
    chk("thr_raise_drop", int'(at[0][1]), 0);

    cyc(0, 4'hF, 3, 3, 3, 3);
    chk("midrun_reset", int'(cnt[0]), 'h3333);
    chk("midrun_reset_ovf", int'(ovf[0]), 0);

    cyc(1, 4'hF, 1, 2, 3, 3);
    cyc(1, 4'h0, 0, 0, 0, 1);
    chk("counts_1234", int'(cnt[0]), 'h4321);
`ifdef BSG_COUNTER_SNAPSHOT_EN
    snapshot = 1'b1;
    cyc(1, 4'hF, 0, 0, 0, 0);
    snapshot = 1'b0;
    chk("snap_count", int'(snap[0]), 'h4321);
    chk("snap_v", int'(snap_v[0]), 1);
    chk("snap_cleared_counts", int'(cnt[0]), 0);
    cyc(1, 4'h0, 1, 1, 1, 1);
    chk("snap_held", int'(snap[1]), 'h4321);
`else
    cyc(1, 4'hF, 0, 0, 0, 0);
    chk("final_clear", int'(cnt[0]), 0);
    cyc(1, 4'h0, 1, 1, 1, 1);
`endif
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bsg_counter_clear_up_multi.md
Name: bsg_counter_clear_up_multi

Overview:
- Bank of els_p independent up-counters on one clock.
- Each channel supports per-cycle increments of 0..max_step_p, a synchronous clear, a selectable wrap or saturate mode at max_val_p, a sticky overflow flag, and a shared-threshold compare output.
- Used by performance-monitor and credit/occupancy logic that needs many counters with uniform behaviour instead of instantiating single-step counters one at a time.

Parameters:
- els_p, 4: number of channels; must be >= 1.
- max_val_p, none (must be set): largest count value; ptr_width_lp = BSG_WIDTH(max_val_p).
- max_step_p, 1: largest per-cycle increment; must be 1..max_val_p; step_width_lp = BSG_WIDTH(max_step_p).
- init_val_p, 0: count value loaded at reset; must be <= max_val_p.
- saturate_p, 0: 0 = wrap modulo (max_val_p+1); 1 = saturate at max_val_p.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_n_i  input  1  synchronous, active-low reset.
- clear_i  input  els_p  per-channel synchronous clear.
- up_i  input  els_p*step_width_lp  per-channel increment; channel i occupies bits [i*step_width_lp +: step_width_lp].
- thresh_i  input  ptr_width_lp  threshold shared by all channels.
- count_o  output  els_p*ptr_width_lp  registered counts, packed the same way as up_i.
- overflow_o  output  els_p  sticky per-channel overflow flag, registered.
- at_thresh_o  output  els_p  per-channel flag, high when count_o[i] >= thresh_i; combinational from registered count_o and thresh_i.

Behaviour:
- Reset (reset_n_i == 0 at a posedge)
  - count_o[i] <= init_val_p for every channel; overflow_o <= 0.
  - Reset overrides clear_i and up_i.
  - Reset asserted mid-count takes effect on that edge; no partial updates.
- Per-channel next-value computation, done at width ptr_width_lp+1 so no carry is lost:
  - base = clear_i[i] ? 0 : count_o[i]
  - sum = base + up_i[i]
- Update rule:
  - sum <= max_val_p: count <= sum.
  - sum > max_val_p and saturate_p=0: count <= sum - (max_val_p+1); the wrap is exact for non-power-of-two max_val_p.
  - sum > max_val_p and saturate_p=1: count <= max_val_p.
- Overflow flag:
  - Set on any cycle where sum > max_val_p.
  - Cleared only by clear_i[i] or reset.
  - Clear and up in the same cycle: clear takes effect first, then up is added, so count <= up_i[i] and overflow_o[i] <= 0.
  - Because max_step_p <= max_val_p, a cleared channel can never overflow in that cycle.
- up_i[i] == 0 with clear_i[i] == 0: channel holds its value.
- Latency: count_o and overflow_o reflect inputs one cycle later; at_thresh_o follows count_o and thresh_i with no extra cycle.
- Channels are fully independent; there is no cross-channel interaction.
- Simulation-only input checks (excluded from synthesis), applied when reset_n_i === 1:
  - Error if up_i[i] > max_step_p.
  - Error on an invalid parameter combination at elaboration.

Optional Feature:
- Macro: BSG_COUNTER_SNAPSHOT_EN.
- With the macro defined, the block adds:
  - input snapshot_i (1 bit).
  - output snap_count_o (els_p*ptr_width_lp).
  - output snap_v_o (1 bit).
- Snapshot behaviour:
  - On a posedge with snapshot_i=1, all channels' current count_o values are copied into snap_count_o together, and snap_v_o <= 1.
  - Snapshot and a same-cycle clear/up: the pre-update values are captured.
  - snap_v_o stays high until the next reset; snap_count_o resets to 0.
- Without the macro: the ports are absent, the shadow registers are not built, and the block is otherwise identical.

Test Plan:
- Reset: els_p=4, max_val_p=9, init_val_p=3; hold reset_n_i=0 for 2 cycles with up_i all max -> count_o all 3, overflow_o=0, at_thresh_o matches 3>=thresh_i.
- Wrap: max_val_p=9, saturate_p=0, max_step_p=3; channel 0 at 8, up=3 -> count 1, overflow_o[0]=1; the flag stays 1 after further up=1 cycles.
- Saturate: same setup with saturate_p=1; at 8, up=3 -> count 9, overflow_o=1; next up=2 -> stays 9.
- Clear plus up: channel 2 at 7 with overflow_o=1; clear_i[2]=1, up=2 -> count 2, overflow 0; other channels are unaffected.
- Threshold: thresh_i=5, channel counts 4 -> 5 -> 6 -> at_thresh_o 0,1,1; changing thresh_i to 7 in the same cycle drops the flag immediately.
- Snapshot (macro on): counts {1,2,3,4}, snapshot_i=1 with clear_i=4'b1111 -> snap_count_o={1,2,3,4}, snap_v_o=1, count_o all 0.
